// File: rtl/icache_fetch_responder.sv
// Direct-mapped, read-only instruction cache serving the fetch stage with a BUSYWAIT stall.
// Optional hit/miss counters are built only when ICACHE_PERF_COUNT_EN is defined.
module icache_fetch_responder #(
    parameter int LINES          = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 32 - $clog2(LINES) - 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  ADDRESS,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic [27:0]  MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT,
    output logic [31:0]  HIT_COUNT,
    output logic [31:0]  MISS_COUNT
);

    localparam int IDX_W = $clog2(LINES);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MEM_READ = 2'd1;
    localparam logic [1:0] S_UPDATE   = 2'd2;

    if (WORDS_PER_LINE != 4 || TAG_W != 28 - IDX_W) begin : g_bad_cfg
        $error("icache_fetch_responder: unsupported LINES/WORDS_PER_LINE/TAG_W combination");
    end

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [127:0]     data_mem [LINES];
    logic [LINES-1:0] valid;
    logic [1:0]       state;
    logic [27:0]      miss_block;
    logic [127:0]     fill_data;
    logic [31:0]      instr_q;

    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic [1:0]       offset;
    logic [IDX_W-1:0] fill_index;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;
    logic             idle_hit;
    logic [31:0]      hit_word;
    logic             unused_addr_lsb;

    assign index      = ADDRESS[IDX_W+3:4];
    assign tag        = ADDRESS[31:IDX_W+4];
    assign offset     = ADDRESS[3:2];
    assign fill_index = miss_block[IDX_W-1:0];
    assign fill_tag   = miss_block[27:IDX_W];
    assign unused_addr_lsb = ^ADDRESS[1:0];

    assign hit      = valid[index] && (tag_mem[index] == tag);
    assign idle_hit = (state == S_IDLE) && hit;
    assign hit_word = data_mem[index][{offset, 5'b0} +: 32];

    // Reset masks the stall so the pipeline is never frozen while held in reset.
    assign BUSYWAIT    = !RESET && !idle_hit;
    assign INSTRUCTION = idle_hit ? hit_word : instr_q;
    assign MEM_READ    = (state == S_MEM_READ);
    assign MEM_ADDRESS = miss_block;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            valid   <= '0;
            instr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hit) instr_q <= hit_word;
                    else     state   <= S_MEM_READ;
                end
                S_MEM_READ: begin
                    if (!MEM_BUSYWAIT) state <= S_UPDATE;
                end
                S_UPDATE: begin
                    valid[fill_index] <= 1'b1;
                    state             <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Refill works from the block latched at the miss, so ADDRESS glitches cannot redirect it.
    always_ff @(posedge CLK) begin
        if (state == S_IDLE && !hit)
            miss_block <= ADDRESS[31:4];
        if (state == S_MEM_READ && !MEM_BUSYWAIT)
            fill_data <= MEM_READDATA;
        if (state == S_UPDATE) begin
            data_mem[fill_index] <= fill_data;
            tag_mem[fill_index]  <= fill_tag;
        end
    end

`ifdef ICACHE_PERF_COUNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (idle_hit && hit_cnt != 32'hFFFF_FFFF)
                hit_cnt <= hit_cnt + 32'd1;
            if (state == S_IDLE && !hit && miss_cnt != 32'hFFFF_FFFF)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign HIT_COUNT  = hit_cnt;
    assign MISS_COUNT = miss_cnt;
`else
    assign HIT_COUNT  = 32'd0;
    assign MISS_COUNT = 32'd0;
`endif

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Randomized self-checking bench for icache_fetch_responder against a line-presence model.
module tb_icache_fetch_responder;

    localparam int LINES = 8;
    localparam int IDX_W = 3;

    logic         CLK;
    logic         RESET;
    logic [31:0]  ADDRESS;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
    logic [31:0]  HIT_COUNT;
    logic [31:0]  MISS_COUNT;

    icache_fetch_responder #(.LINES(LINES)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ADDRESS      (ADDRESS),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT),
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int total = 0;
    int bad   = 0;

    // Reference state: which block each line holds, plus expected counters.
    bit          m_valid [LINES];
    logic [27:0] m_block [LINES];
    logic [31:0] last_instr;
    int          exp_hits;
    int          exp_misses;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] mem_block(input logic [27:0] b);
        logic [127:0] blk;
        if (b == 28'd0)
            return {32'h00000013, 32'h002081B3, 32'h00100113, 32'h00400093};
        for (int i = 0; i < 4; i++)
            blk[i*32 +: 32] = (({4'b0, b} << 2) + 32'(i)) * 32'h9E3779B1 ^ 32'h5A5A_0F0F;
        return blk;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [127:0] blk;
        blk = mem_block(a[31:4]);
        return blk[{a[3:2], 5'b0} +: 32];
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'(a[IDX_W+3:4]);
    endfunction

    function automatic logic [127:0] junk128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        last_instr = 32'd0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Present one fetch starting just after a posedge; act as instruction memory with
    // latency m (MEM_BUSYWAIT low on the m-th cycle MEM_READ is high). If glitch is set,
    // ADDRESS jumps to g_addr on the first MEM_READ cycle and the task returns after the
    // refill-write cycle, leaving the cache to look up g_addr.
    task automatic fetch(input logic [31:0] a, input int m, input bit glitch, input logic [31:0] g_addr);
        bit exp_hit;
        bit done;
        int bw_cyc;
        int rd_cyc;
        exp_hit = m_valid[line_of(a)] && (m_block[line_of(a)] == a[31:4]);
        ADDRESS = a;
        bw_cyc  = 0;
        rd_cyc  = 0;
        done    = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            MEM_READDATA = junk128();
            MEM_BUSYWAIT = 1'($urandom_range(0, 1));
            if (MEM_READ) begin
                rd_cyc++;
                MEM_BUSYWAIT = (rd_cyc != m);
                if (rd_cyc == m) MEM_READDATA = mem_block(a[31:4]);
                if (glitch && rd_cyc == 1) ADDRESS = g_addr;
            end
            #3;
            if (MEM_READ) check_eq("mem_address", 32'(MEM_ADDRESS), 32'(a[31:4]));
            if (BUSYWAIT) begin
                bw_cyc++;
                check_eq("instr_hold", INSTRUCTION, last_instr);
                if (glitch && bw_cyc == m + 2) done = 1'b1;
            end else begin
                check_eq("instr", INSTRUCTION, mem_word(a));
                last_instr = mem_word(a);
                exp_hits++;
                done = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        check_eq("finished", 32'(done), 32'd1);
        check_eq("busy_cycles", 32'(bw_cyc), exp_hit ? 32'd0 : 32'(m + 2));
        check_eq("read_cycles", 32'(rd_cyc), exp_hit ? 32'd0 : 32'(m));
        if (!exp_hit) begin
            exp_misses++;
            m_valid[line_of(a)] = 1'b1;
            m_block[line_of(a)] = a[31:4];
        end
    endtask

    task automatic check_counters(input string name);
`ifdef ICACHE_PERF_COUNT_EN
        check_eq({name, "_hits"},   HIT_COUNT,  32'(exp_hits));
        check_eq({name, "_misses"}, MISS_COUNT, 32'(exp_misses));
`else
        check_eq({name, "_hits"},   HIT_COUNT,  32'd0);
        check_eq({name, "_misses"}, MISS_COUNT, 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] base [3];
        logic [31:0] a;
        base[0] = 32'h0000_0000;
        base[1] = 32'h0000_1000;
        base[2] = 32'hFFFF_FF00;

        RESET        = 1'b1;
        ADDRESS      = 32'd0;
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = '0;
        model_reset();
        @(posedge CLK);
        #2;
        check_eq("rst_busywait", 32'(BUSYWAIT), 32'd0);
        check_eq("rst_mem_read", 32'(MEM_READ), 32'd0);
        check_eq("rst_instr", INSTRUCTION, 32'd0);
        check_counters("rst");
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Cold miss, then the rest of the line hits.
        fetch(32'h0000_0000, 3, 1'b0, 32'd0);
        fetch(32'h0000_0004, 1, 1'b0, 32'd0);
        fetch(32'h0000_0008, 1, 1'b0, 32'd0);
        fetch(32'h0000_000C, 1, 1'b0, 32'd0);
        check_counters("cold");

        // Conflict on index 0 in both directions.
        fetch(32'h0000_0080, 2, 1'b0, 32'd0);
        fetch(32'h0000_0000, 1, 1'b0, 32'd0);
        fetch(32'h0000_0080, 2, 1'b0, 32'd0);

        // ADDRESS glitch during refill of block 0.
        fetch(32'h0000_0000, 3, 1'b1, 32'h0000_0040);
        fetch(32'h0000_0040, 2, 1'b0, 32'd0);
        fetch(32'h0000_0000, 1, 1'b0, 32'd0);

        // Reset while the refill is outstanding.
        ADDRESS      = 32'h0000_0200;
        MEM_BUSYWAIT = 1'b1;
        @(posedge CLK);
        #1;
        check_eq("pre_rst_mem_read", 32'(MEM_READ), 32'd1);
        #1;
        RESET = 1'b1;
        #1;
        check_eq("midrst_mem_read", 32'(MEM_READ), 32'd0);
        check_eq("midrst_busywait", 32'(BUSYWAIT), 32'd0);
        check_eq("midrst_instr", INSTRUCTION, 32'd0);
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = mem_block(28'h20);
        @(posedge CLK);
        #1;
        RESET        = 1'b0;
        MEM_BUSYWAIT = 1'b1;
        model_reset();
        check_counters("midrst");
        fetch(32'h0000_0000, 2, 1'b0, 32'd0);
        fetch(32'h0000_0200, 1, 1'b0, 32'd0);

        // Random traffic over a few regions, including the top of the address space.
        for (int n = 0; n < 300; n++) begin
            a = base[$urandom_range(0, 2)] + 32'($urandom_range(0, 255));
            fetch(a, $urandom_range(1, 4), 1'b0, 32'd0);
        end
        fetch(32'hFFFF_FFFC, 2, 1'b0, 32'd0);
        fetch(32'hFFFF_FFF0, 1, 1'b0, 32'd0);
        check_counters("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
